imem_fetch_unit: RTL

- Read-side initiator for the IMem block RAM port (clka, wea, addra, dina, douta).
- Owns the program counter and drives addra. Absorbs the one-cycle synchronous read latency.
- Delivers instruction words to the decoder over a valid/ready handshake, through a 2-entry output buffer.
- Supports PC redirect (branch/jump) with flush, and counts retired fetches.

---
 rtl/imem_fetch_unit.sv | 101 ++++++++++
 1 files changed

// File: rtl/imem_fetch_unit.sv
// Instruction fetch front end: owns the PC, absorbs the one-cycle IMem read
// latency and presents words to the decoder through a 2-entry buffer.
module imem_fetch_unit #(
   parameter int                ADDR_W   = 10,
   parameter int                DATA_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clka,
   input  logic              rst,
   input  logic              run,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_din,
   input  logic [DATA_W-1:0] imem_dout,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   output logic [31:0]       fetch_count
);

   typedef enum logic {IDLE, FETCH} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [1:0]        count;
   logic              head;
   logic              tail;
   logic [DATA_W-1:0] fifo_data [2];
   logic [ADDR_W-1:0] fifo_pc   [2];
   logic [31:0]       fcount;
   logic              pop;
   logic              issue;
   logic [2:0]        occ;

   assign imem_we     = 1'b0;
   assign imem_din    = '0;
   assign imem_addr   = pc;
   assign instr_valid = (count != 2'd0);
   assign instr_data  = fifo_data[head];
   assign instr_pc    = fifo_pc[head];
   assign fetch_count = fcount;

   // Occupancy after this edge's pop, counting the word still in the RAM pipe.
   always_comb begin
      pop   = instr_valid & instr_ready;
      occ   = 3'(count) + 3'(inflight) - 3'(pop);
      issue = (state == FETCH) & ~redirect_valid & (occ < 3'd2);
   end

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         count       <= 2'd0;
         head        <= 1'b0;
         tail        <= 1'b0;
         fcount      <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_pc[i]   <= '0;
         end
      end else begin
         state <= run ? FETCH : IDLE;
         if (pop)
            fcount <= fcount + 32'd1;
         if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            count    <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
         end else begin
            inflight <= issue;
            if (issue) begin
               inflight_pc <= pc;
               pc          <= pc + ADDR_W'(1);
            end
            if (inflight) begin
               fifo_data[tail] <= imem_dout;
               fifo_pc[tail]   <= inflight_pc;
               tail            <= ~tail;
            end
            if (pop)
               head <= ~head;
            case ({inflight, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule
